// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display path: digit count, glyphs
// and segment bit positions. All glyphs are active-low, ordered {g,f,e,d,c,b,a}.
package display_pkg;

  localparam int N_DIGITS = 8;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // Dash lights only the middle bar.
  localparam logic [6:0] SEG_DASH  = ~(7'b1 << SEG_G);

  localparam logic [0:9][6:0] GLYPH = {
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment glyph.
// Non-decimal nibbles (A-F) render as a dash.
module bcd_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (nib <= 4'd9) seg = GLYPH[nib];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode driver with double-buffered value,
// per-slot ghost blanking and optional leading-zero suppression.
module seg7_scan_driver
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500,
  parameter int          DIV_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digits,
  input  logic        load,
  input  logic [7:0]  dp_in,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      stage_q, stage_d, disp_q, disp_d;
  logic [7:0]       stage_dp_q, stage_dp_d, disp_dp_q, disp_dp_d;
  logic             pend_q, pend_d;
  logic             bnd_q, bnd_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             fs_q, fs_d;

  logic                tick, frame_bnd;
  logic [3:0]          nib;
  logic [6:0]          glyph;
  logic [N_DIGITS-1:0] lz_mask;
  logic                zero_run;
  logic                blank_cur;

  always_comb begin
    tick      = (cnt_q == DIV_W'(SCAN_DIV - 1));
    frame_bnd = tick && (idx_q == 3'd7);
    cnt_d     = tick ? '0 : cnt_q + DIV_W'(1);
    idx_d     = tick ? idx_q + 3'd1 : idx_q;
  end

  // A load landing on the frame boundary goes straight to the display so
  // the new value is not delayed by a whole frame.
  always_comb begin
    stage_d    = stage_q;
    stage_dp_d = stage_dp_q;
    disp_d     = disp_q;
    disp_dp_d  = disp_dp_q;
    pend_d     = pend_q;
    if (load) begin
      stage_d    = digits;
      stage_dp_d = dp_in;
      pend_d     = 1'b1;
    end
    if (frame_bnd) begin
      if (load) begin
        disp_d    = digits;
        disp_dp_d = dp_in;
        pend_d    = 1'b0;
      end else if (pend_q) begin
        disp_d    = stage_q;
        disp_dp_d = stage_dp_q;
        pend_d    = 1'b0;
      end
    end
  end

  // lz_mask[i] is set when digits 7..i are all zero; digit 0 stays clear.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (disp_q[4*i +: 4] == 4'd0);
      lz_mask[i] = zero_run;
    end
  end

  assign nib = disp_q[{idx_q, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .nib (nib),
    .seg (glyph)
  );

  always_comb begin
    blank_cur = blank_lz && lz_mask[idx_q];
    an_d      = (cnt_q >= DIV_W'(BLANK_CYC)) ? ~(8'b1 << idx_q) : 8'hFF;
    seg_d     = blank_cur ? SEG_BLANK : glyph;
    dp_d      = blank_cur ? 1'b1 : ~disp_dp_q[idx_q];
    bnd_d     = frame_bnd;
    // Extra stage aligns the pulse with digit 0's first output cycle.
    fs_d      = bnd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      stage_q    <= '0;
      stage_dp_q <= '0;
      disp_q     <= '0;
      disp_dp_q  <= '0;
      pend_q     <= 1'b0;
      bnd_q      <= 1'b0;
      an_q       <= 8'hFF;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stage_q    <= stage_d;
      stage_dp_q <= stage_dp_d;
      disp_q     <= disp_d;
      disp_dp_q  <= disp_dp_d;
      pend_q     <= pend_d;
      bnd_q      <= bnd_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      fs_q       <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a short scan (4 cycles per slot,
// 1 blank cycle, 32-cycle frame); each output cycle of a frame is checked.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [31:0] digits;
  logic        load;
  logic [7:0]  dp_in;
  logic        blank_lz;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  seg7_scan_driver #(
    .SCAN_DIV  (4),
    .BLANK_CYC (1),
    .DIV_W     (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits      (digits),
    .load        (load),
    .dp_in       (dp_in),
    .blank_lz    (blank_lz),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0]     digits;
    logic [7:0]      dp_in;
    logic            blz;
    logic [7:0][6:0] seg;
    logic [7:0]      dpl;
  } vec_t;

  vec_t            vecs [6];
  logic [7:0][6:0] prev_seg;
  logic [7:0]      prev_dpl;

  task automatic check_reset(input string name);
    n_tests++;
    if ({an, seg, dp, frame_start} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL %s: got an=%h seg=%h dp=%b fs=%b, want an=ff seg=7f dp=1 fs=0",
               name, an, seg, dp, frame_start);
    end
  endtask

  task automatic check_cycle(input logic [7:0][6:0] eseg, input logic [7:0] edpl,
                             input int c, input logic efs, input string name);
    int         d;
    logic [7:0] ean;
    d   = c / 4;
    ean = (c % 4 == 0) ? 8'hFF : ~(8'h01 << d);
    n_tests++;
    if ({an, seg, dp, frame_start} !== {ean, eseg[d], edpl[d], efs}) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got an=%h seg=%h dp=%b fs=%b, want an=%h seg=%h dp=%b fs=%b",
               name, c, an, seg, dp, frame_start, ean, eseg[d], edpl[d], efs);
    end
  endtask

  task automatic run_frame(input logic [7:0][6:0] eseg, input logic [7:0] edpl,
                           input string name, input logic fs0);
    for (int c = 0; c < 32; c++) begin
      check_cycle(eseg, edpl, c, (c == 0) && fs0, name);
      @(negedge clk);
    end
  endtask

  // Checks a frame still showing the old value while up to two loads
  // are pulsed into it; blank_lz changes just before the next frame.
  task automatic hold_frame(input logic [7:0][6:0] eseg, input logic [7:0] edpl,
                            input string name, input int la, input logic [31:0] da,
                            input int lb, input logic [31:0] db, input logic [7:0] pd,
                            input logic blz_next);
    for (int c = 0; c < 32; c++) begin
      check_cycle(eseg, edpl, c, c == 0, name);
      if (c == la) begin
        load = 1'b1; digits = da; dp_in = pd;
      end else if (c == lb) begin
        load = 1'b1; digits = db; dp_in = pd;
      end else if (c == la + 1 || c == lb + 1) begin
        load = 1'b0;
      end
      if (c == 31) blank_lz = blz_next;
      @(negedge clk);
    end
  endtask

  task automatic wait_frame(input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (frame_start === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s: frame_start not seen within 40 cycles, want a pulse every 32", name);
    end
  endtask

  initial begin
    vecs[0] = '{32'h00001234, 8'h00, 1'b1,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}, 8'hFF};
    vecs[1] = '{32'h00001234, 8'h00, 1'b0,
                {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19}, 8'hFF};
    vecs[2] = '{32'h0000000A, 8'h02, 1'b0,
                {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h3F}, 8'hFD};
    vecs[3] = '{32'h00102030, 8'hFF, 1'b1,
                {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h24, 7'h40, 7'h30, 7'h40}, 8'hC0};
    vecs[4] = '{32'h00000000, 8'h01, 1'b1,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 8'hFE};
    vecs[5] = '{32'h9876F5E0, 8'h80, 1'b1,
                {7'h10, 7'h00, 7'h78, 7'h02, 7'h3F, 7'h12, 7'h3F, 7'h40}, 8'h7F};

    rst_n    = 1'b0;
    digits   = '0;
    load     = 1'b0;
    dp_in    = '0;
    blank_lz = 1'b0;

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    prev_seg = {8{7'h40}};
    prev_dpl = 8'hFF;
    run_frame(prev_seg, prev_dpl, "idle0", 1'b0);
    run_frame(prev_seg, prev_dpl, "idle1", 1'b1);

    foreach (vecs[v]) begin
      wait_frame("vec_sync");
      hold_frame(prev_seg, prev_dpl, "vec_hold", 12, vecs[v].digits,
                 -1, 32'h0, vecs[v].dp_in, vecs[v].blz);
      run_frame(vecs[v].seg, vecs[v].dpl, "vec_show", 1'b1);
      prev_seg = vecs[v].seg;
      prev_dpl = vecs[v].dpl;
    end

    // Two loads in one frame: the later value wins.
    wait_frame("dbl_sync");
    hold_frame(prev_seg, prev_dpl, "dbl_hold", 5, 32'h11111111,
               20, 32'h22222222, 8'h00, 1'b1);
    prev_seg = {8{7'h24}};
    prev_dpl = 8'hFF;
    run_frame(prev_seg, prev_dpl, "dbl_show", 1'b1);

    // Load captured on the frame-boundary edge shows in the very next frame.
    wait_frame("bnd_sync");
    hold_frame(prev_seg, prev_dpl, "bnd_hold", 30, 32'h87654321,
               -1, 32'h0, 8'h00, 1'b1);
    prev_seg = {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    run_frame(prev_seg, prev_dpl, "bnd_show", 1'b1);
    run_frame(prev_seg, prev_dpl, "bnd_keep", 1'b1);

    // Asynchronous reset in the middle of digit 2's active window.
    wait_frame("rst_sync");
    for (int c = 0; c < 10; c++) begin
      check_cycle(prev_seg, prev_dpl, c, c == 0, "pre_rst");
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1 check_reset("rst_async");
    @(negedge clk);
    check_reset("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    prev_seg = {{7{7'h7F}}, 7'h40};
    prev_dpl = 8'hFF;
    run_frame(prev_seg, prev_dpl, "post_rst0", 1'b0);
    run_frame(prev_seg, prev_dpl, "post_rst1", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
